// File: rtl/led_breathe_multi.sv
// Multi-channel LED intensity engine: per-channel OFF / STATIC / BREATHE / BLINK modes
// driven from one shared ramp, with first-order accumulator PWM for the duty modes.
module led_breathe_multi #(
  parameter int CHANNELS = 4,
  parameter int IW       = 4,
  parameter int RAMP_W   = 24,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [IW-1:0]       cfg_level,
  input  logic [IW:0]         cfg_phase,
  output logic [CHANNELS-1:0] led,
  output logic                sync_pulse
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BREATHE = 2'b10,
    MODE_BLINK   = 2'b11
  } mode_e;

  mode_e               mode_q  [CHANNELS];
  mode_e               mode_d  [CHANNELS];
  logic [IW-1:0]       level_q [CHANNELS];
  logic [IW-1:0]       level_d [CHANNELS];
  logic [IW:0]         phase_q [CHANNELS];
  logic [IW:0]         phase_d [CHANNELS];
  // Only the low IW accumulator bits are kept; the carry bit lives in led_q.
  logic [IW-1:0]       acc_q   [CHANNELS];
  logic [IW-1:0]       acc_d   [CHANNELS];
  logic [RAMP_W-1:0]   cnt_q;
  logic [RAMP_W-1:0]   cnt_d;
  logic [CHANNELS-1:0] led_q;
  logic [CHANNELS-1:0] led_d;
  logic                sync_q;
  logic                sync_d;

  logic [IW:0]         pos     [CHANNELS];
  logic [IW-1:0]       tri_lvl [CHANNELS];
  logic [IW-1:0]       intens  [CHANNELS];
  logic [IW:0]         sum     [CHANNELS];
  logic [31:0]         cfg_ch_ext;

  assign cfg_ch_ext = {{(32-CH_W){1'b0}}, cfg_ch};

  // Next-state: shared ramp, sync pulse, config load and per-channel PWM/blink.
  always_comb begin
    cnt_d  = cnt_q + {{(RAMP_W-1){1'b0}}, 1'b1};
    sync_d = &cnt_q;
    for (int n = 0; n < CHANNELS; n++) begin
      mode_d[n]  = mode_q[n];
      level_d[n] = level_q[n];
      phase_d[n] = phase_q[n];
      acc_d[n]   = acc_q[n];
      led_d[n]   = 1'b0;

      // Out-of-range cfg_ch matches no channel, so such writes are dropped.
      if (cfg_we && (cfg_ch_ext == 32'(n))) begin
        mode_d[n]  = mode_e'(cfg_mode);
        level_d[n] = cfg_level;
        phase_d[n] = cfg_phase;
      end else begin
        mode_d[n]  = mode_q[n];
        level_d[n] = level_q[n];
        phase_d[n] = phase_q[n];
      end

      pos[n]     = cnt_q[RAMP_W-1 -: IW+1] + phase_q[n];
      tri_lvl[n] = pos[n][IW] ? pos[n][IW-1:0] : ~pos[n][IW-1:0];
      if (mode_q[n] == MODE_BREATHE) begin
        intens[n] = tri_lvl[n];
      end else begin
        intens[n] = level_q[n];
      end
      sum[n] = {1'b0, acc_q[n]} + {1'b0, intens[n]};

      case (mode_q[n])
        MODE_STATIC, MODE_BREATHE: begin
          acc_d[n] = sum[n][IW-1:0];
          led_d[n] = sum[n][IW];
        end
        MODE_BLINK: begin
          acc_d[n] = acc_q[n];
          led_d[n] = pos[n][IW];
        end
        default: begin
          acc_d[n] = {IW{1'b0}};
          led_d[n] = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= {RAMP_W{1'b0}};
      led_q  <= {CHANNELS{1'b0}};
      sync_q <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        mode_q[n]  <= MODE_OFF;
        level_q[n] <= {IW{1'b0}};
        phase_q[n] <= {(IW+1){1'b0}};
        acc_q[n]   <= {IW{1'b0}};
      end
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      sync_q <= sync_d;
      for (int n = 0; n < CHANNELS; n++) begin
        mode_q[n]  <= mode_d[n];
        level_q[n] <= level_d[n];
        phase_q[n] <= phase_d[n];
        acc_q[n]   <= acc_d[n];
      end
    end
  end

  assign led        = led_q;
  assign sync_pulse = sync_q;

endmodule

// File: tb/tb_led_breathe_multi.sv
// Scoreboard bench for led_breathe_multi: a 4-channel and a 3-channel build share stimulus
// and are compared every cycle against a per-cycle arithmetic reference model.
module tb_led_breathe_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [3:0] cfg_level = 4'd0;
  logic [4:0] cfg_phase = 5'd0;
  logic [3:0] led4;
  logic       sync4;
  logic [2:0] led3;
  logic       sync3;

  led_breathe_multi #(.CHANNELS(4), .IW(4), .RAMP_W(8)) u4 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_level(cfg_level), .cfg_phase(cfg_phase), .led(led4), .sync_pulse(sync4)
  );

  led_breathe_multi #(.CHANNELS(3), .IW(4), .RAMP_W(8)) u3 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_level(cfg_level), .cfg_phase(cfg_phase), .led(led3), .sync_pulse(sync3)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (integers, spec-level arithmetic)
  int m_cnt;
  int m_mode [4];
  int m_lvl  [4];
  int m_ph   [4];
  int m_acc  [4];

  logic [4:0] exp_q [$];   // {sync, led[3:0]} expected after the next posedge
  logic [3:0] obs_led;
  logic       obs_sync;

  task automatic chk(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // One clock cycle: observe previous edge's outputs, drive inputs, predict next edge.
  task automatic cycle(input bit r, input bit we, input int ch, input int mode,
                       input int lvl, input int ph);
    logic [3:0] e_led;
    logic       e_sync;
    int p, tl, k, s;
    @(negedge clk);
    obs_led  = led4;
    obs_sync = sync4;
    rst       = r;
    cfg_we    = we;
    cfg_ch    = 2'(ch);
    cfg_mode  = 2'(mode);
    cfg_level = 4'(lvl);
    cfg_phase = 5'(ph);
    e_led  = 4'd0;
    e_sync = 1'b0;
    if (r) begin
      m_cnt = 0;
      for (int n = 0; n < 4; n++) begin
        m_mode[n] = 0; m_lvl[n] = 0; m_ph[n] = 0; m_acc[n] = 0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        p  = ((m_cnt / 8) + m_ph[n]) % 32;
        tl = (p >= 16) ? (p - 16) : (15 - p);
        case (m_mode[n])
          1, 2: begin
            k = (m_mode[n] == 1) ? m_lvl[n] : tl;
            s = m_acc[n] + k;
            e_led[n] = (s >= 16);
            m_acc[n] = s % 16;
          end
          3: e_led[n] = (p >= 16);
          default: begin
            m_acc[n] = 0;
            e_led[n] = 1'b0;
          end
        endcase
      end
      e_sync = (m_cnt == 255);
      m_cnt  = (m_cnt + 1) % 256;
      if (we && ch < 4) begin
        m_mode[ch] = mode; m_lvl[ch] = lvl; m_ph[ch] = ph;
      end
    end
    exp_q.push_back({e_sync, e_led});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, $urandom_range(3, 0), $urandom_range(3, 0),
          $urandom_range(15, 0), $urandom_range(31, 0));
  endtask

  task automatic wr(input int ch, input int mode, input int lvl, input int ph);
    cycle(1'b0, 1'b1, ch, mode, lvl, ph);
  endtask

  // Count high cycles of u4.led[ch] over n consecutive edges.
  task automatic count_hi(input int ch, input int n, output int c);
    c = 0;
    for (int i = 0; i <= n; i++) begin
      idle();
      if (i > 0) c += int'(obs_led[ch]);
    end
  endtask

  // Monitor: compare both builds against the queued prediction after every posedge.
  logic [4:0]  mon_e;
  logic [9:0]  mon_act;
  logic [9:0]  mon_want;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e    = exp_q.pop_front();
        mon_act  = {sync3, led3, sync4, led4[3:0], 1'b0};
        mon_want = {mon_e[4], mon_e[2:0], mon_e[4], mon_e[3:0], 1'b0};
        n_tests++;
        if (mon_act !== mon_want) begin
          n_fail++;
          $display("FAIL scoreboard t=%0t: got sync3/led3/sync4/led4=%b, expected %b",
                   $time, mon_act[9:1], mon_want[9:1]);
        end
      end
    end
  end

  int c;
  int found;

  initial begin
    repeat (3) cycle(1'b1, 1'b0, 0, 0, 0, 0);

    // First sync pulse 256 edges after the last reset edge
    found = -1;
    for (int i = 1; i <= 300; i++) begin
      idle();
      if (i >= 2 && obs_sync && found < 0) found = i - 1;
    end
    chk("first_sync_edge", found, 256);

    // STATIC duty
    wr(0, 1, 4, 0);
    repeat (3) idle();
    count_hi(0, 16, c); chk("static4_w1", c, 4);
    count_hi(0, 16, c); chk("static4_w2", c, 4);
    wr(0, 1, 0, 0);
    repeat (3) idle();
    count_hi(0, 16, c); chk("static0", c, 0);
    wr(0, 1, 15, 0);
    repeat (3) idle();
    count_hi(0, 16, c); chk("static15_w1", c, 15);
    count_hi(0, 16, c); chk("static15_w2", c, 15);

    // BREATHE full period
    wr(0, 2, 0, 0);
    repeat (3) idle();
    count_hi(0, 256, c); chk("breathe_period_120pm1", int'(c >= 119 && c <= 121), 1);

    // Phase-shifted breathe on ch1, blink on ch2
    wr(1, 2, 0, 16);
    repeat (300) idle();
    wr(2, 3, 0, 0);
    repeat (3) idle();
    count_hi(2, 256, c); chk("blink_high_128", c, 128);

    // ch3 valid in the 4-channel build, out of range in the 3-channel build
    wr(3, 1, 15, 0);
    repeat (3) idle();
    count_hi(3, 16, c); chk("ch3_static15", c, 15);

    // Reset mid-operation
    cycle(1'b1, 1'b0, 0, 0, 0, 0);
    idle();
    chk("reset_mid_led", int'(obs_led), 0);
    repeat (40) idle();
    chk("after_reset_off", int'(obs_led), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399, 0) == 0) begin
        cycle(1'b1, 1'b0, 0, 0, 0, 0);
      end else if ($urandom_range(5, 0) == 0) begin
        wr($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(15, 0),
           $urandom_range(31, 0));
      end else begin
        idle();
      end
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
